// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: bus widths, field offsets used by the
// execute/write-back stages, load-op bit indices and the forwarding bus layout.
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_W = 175;
   localparam int MS_TO_WS_BUS_W = 168;
   localparam int MS_FWD_BUS_W   = 39;

   localparam int DATA_W  = 32;
   localparam int CSR_W   = 34;
   localparam int REG_W   = 5;
   localparam int LD_OP_W = 5;

   // execute -> memory bus, LSB positions
   localparam int ES_PC_LSB      = 0;
   localparam int ES_ALU_LSB     = 32;
   localparam int ES_DEST_LSB    = 64;
   localparam int ES_GR_WE_BIT   = 69;
   localparam int ES_LD_OP_LSB   = 70;
   localparam int ES_RES_MEM_BIT = 75;
   localparam int ES_MEM_REQ_BIT = 76;
   localparam int ES_CSR_LSB     = 77;
   localparam int ES_RKD_LSB     = 111;
   localparam int ES_RJ_LSB      = 143;

   // memory -> write-back bus, LSB positions
   localparam int WS_PC_LSB     = 0;
   localparam int WS_RESULT_LSB = 32;
   localparam int WS_DEST_LSB   = 64;
   localparam int WS_GR_WE_BIT  = 69;
   localparam int WS_CSR_LSB    = 70;
   localparam int WS_RKD_LSB    = 104;
   localparam int WS_RJ_LSB     = 136;

   // one-hot ld_op field, {b,h,w,bu,hu} from MSB to LSB
   typedef enum int unsigned {
      LD_HU = 0,
      LD_BU = 1,
      LD_W  = 2,
      LD_H  = 3,
      LD_B  = 4
   } ld_bit_e;

   typedef struct packed {
      logic              we;
      logic              block;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] data;
   } ms_fwd_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-facing signals of the memory stage. The stage itself uses the slave
// modport; the surrounding pipeline (or a bench) uses master.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic                      ws_allowin;
   logic                      ms_allowin;
   logic                      es_to_ms_valid;
   logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus;
   logic                      ms_to_ws_valid;
   logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus;
   logic                      data_sram_data_ok;
   logic [DATA_W-1:0]         data_sram_rdata;
   logic                      wb_ex;
   logic [MS_FWD_BUS_W-1:0]   ms_fwd_bus;

   modport slave (
      input  ws_allowin, es_to_ms_valid, es_to_ms_bus,
             data_sram_data_ok, data_sram_rdata, wb_ex,
      output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
   );

   modport master (
      output ws_allowin, es_to_ms_valid, es_to_ms_bus,
             data_sram_data_ok, data_sram_rdata, wb_ex,
      input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
   );

endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: picks the addressed byte/halfword out of a 32-bit load word and
// sign- or zero-extends it according to the one-hot ld_op. Purely combinational.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [LD_OP_W-1:0] i_ld_op,
   input  logic [1:0]         i_addr,
   input  logic [DATA_W-1:0]  i_rdata,
   output logic [DATA_W-1:0]  o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   // ld_w (and a malformed all-zero op) falls through to the full word
   always_comb begin
      o_data = i_rdata;
      if (i_ld_op[LD_B])
         o_data = {{24{w_byte[7]}}, w_byte};
      else if (i_ld_op[LD_BU])
         o_data = {24'd0, w_byte};
      else if (i_ld_op[LD_H])
         o_data = {{16{w_half[15]}}, w_half};
      else if (i_ld_op[LD_HU])
         o_data = {16'd0, w_half};
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: holds one instruction, waits for its data-SRAM response, aligns
// load data and discards responses owed to flushed loads. Define MS_FWD_EN to forward values to decode.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   mem_stage_if.slave ms_if
);

   logic [ES_TO_MS_BUS_W-1:0] r_bus;
   logic                      r_ms_valid;
   logic                      r_got_data;
   logic [DATA_W-1:0]         r_data_buf;
   logic [1:0]                r_drop_cnt;

   logic                      w_mem_req;
   logic                      w_res_from_mem;
   logic                      w_gr_we;
   logic [LD_OP_W-1:0]        w_ld_op;
   logic [REG_W-1:0]          w_dest;
   logic [DATA_W-1:0]         w_alu_result;
   logic                      w_cap;
   logic                      w_drop;
   logic                      w_owe;
   logic                      w_ready_go;
   logic                      w_allowin;
   logic                      w_latch;
   logic [2:0]                w_drop_sum;
   logic [DATA_W-1:0]         w_ld_src;
   logic [DATA_W-1:0]         w_ld_val;
   logic [DATA_W-1:0]         w_final;
   logic [MS_TO_WS_BUS_W-1:0] w_ws_bus;
   ms_fwd_t                   w_fwd;

   assign w_mem_req      = r_bus[ES_MEM_REQ_BIT];
   assign w_res_from_mem = r_bus[ES_RES_MEM_BIT];
   assign w_gr_we        = r_bus[ES_GR_WE_BIT];
   assign w_ld_op        = r_bus[ES_LD_OP_LSB +: LD_OP_W];
   assign w_dest         = r_bus[ES_DEST_LSB +: REG_W];
   assign w_alu_result   = r_bus[ES_ALU_LSB +: DATA_W];

   // A response belongs to the resident instruction only once every response
   // owed to flushed loads has drained.
   assign w_cap      = ms_if.data_sram_data_ok && (r_drop_cnt == 2'd0);
   assign w_drop     = ms_if.data_sram_data_ok && (r_drop_cnt != 2'd0);
   assign w_ready_go = !w_mem_req || r_got_data || w_cap;
   assign w_allowin  = !r_ms_valid || (w_ready_go && ms_if.ws_allowin);
   assign w_latch    = ms_if.es_to_ms_valid && w_allowin;
   assign w_owe      = ms_if.wb_ex && r_ms_valid && w_mem_req && !r_got_data && !w_cap;

   assign w_drop_sum = {1'b0, r_drop_cnt} - {2'b00, w_drop} + {2'b00, w_owe};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ms_valid <= 1'b0;
         r_got_data <= 1'b0;
         r_drop_cnt <= 2'd0;
      end else begin
         if (ms_if.wb_ex)
            r_ms_valid <= 1'b0;
         else if (w_allowin)
            r_ms_valid <= ms_if.es_to_ms_valid;

         // a newly latched instruction never inherits the previous response
         if (ms_if.wb_ex || w_latch)
            r_got_data <= 1'b0;
         else if (w_cap)
            r_got_data <= 1'b1;

         r_drop_cnt <= w_drop_sum[2] ? 2'd3 : w_drop_sum[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bus      <= '0;
         r_data_buf <= '0;
      end else begin
         if (w_latch)
            r_bus <= ms_if.es_to_ms_bus;
         if (w_cap)
            r_data_buf <= ms_if.data_sram_rdata;
      end
   end

   assign w_ld_src = w_cap ? ms_if.data_sram_rdata : r_data_buf;

   load_align u_align (
      .i_ld_op (w_ld_op),
      .i_addr  (w_alu_result[1:0]),
      .i_rdata (w_ld_src),
      .o_data  (w_ld_val)
   );

   assign w_final = w_res_from_mem ? w_ld_val : w_alu_result;

   always_comb begin
      w_ws_bus = '0;
      w_ws_bus[WS_PC_LSB +: DATA_W]     = r_bus[ES_PC_LSB +: DATA_W];
      w_ws_bus[WS_RESULT_LSB +: DATA_W] = w_final;
      w_ws_bus[WS_DEST_LSB +: REG_W]    = w_dest;
      w_ws_bus[WS_GR_WE_BIT]            = w_gr_we;
      w_ws_bus[WS_CSR_LSB +: CSR_W]     = r_bus[ES_CSR_LSB +: CSR_W];
      w_ws_bus[WS_RKD_LSB +: DATA_W]    = r_bus[ES_RKD_LSB +: DATA_W];
      w_ws_bus[WS_RJ_LSB +: DATA_W]     = r_bus[ES_RJ_LSB +: DATA_W];
   end

   always_comb begin
      w_fwd      = '0;
      w_fwd.we   = r_ms_valid && w_gr_we;
      w_fwd.dest = w_dest;
`ifdef MS_FWD_EN
      w_fwd.block = w_fwd.we && w_res_from_mem && !w_ready_go;
      w_fwd.data  = w_final;
`else
      // without a forwarding path decode must stall on any destination match
      w_fwd.block = w_fwd.we;
      w_fwd.data  = '0;
`endif
   end

   assign ms_if.ms_allowin     = w_allowin;
   assign ms_if.ms_to_ws_valid = r_ms_valid && w_ready_go;
   assign ms_if.ms_to_ws_bus   = w_ws_bus;
   assign ms_if.ms_fwd_bus     = w_fwd;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: random instructions against a reference built from the
// stage's architectural rules (handshake, load extension, owed-response counting).
module tb_mem_stage;
   import mem_stage_pkg::*;

   typedef struct {
      logic [31:0] rj, rkd, alu, pc;
      logic [33:0] csr;
      logic        mem_req, res_mem, gr_we;
      logic [4:0]  ld_op, dest;
   } insn_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   model_owed = 0;

   always #5 clk = ~clk;

   mem_stage_if ms_if();

   mem_stage dut (
      .clk   (clk),
      .reset (reset),
      .ms_if (ms_if)
   );

   function automatic insn_t rand_insn(input bit mem);
      insn_t t;
      t.rj      = $urandom;
      t.rkd     = $urandom;
      t.alu     = $urandom;
      t.pc      = $urandom;
      t.csr     = {2'($urandom_range(0, 3)), 32'($urandom)};
      t.mem_req = mem;
      t.res_mem = mem ? ($urandom_range(0, 3) != 0) : 1'b0;
      t.ld_op   = t.res_mem ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
      t.gr_we   = $urandom_range(0, 3) != 0;
      t.dest    = 5'($urandom);
      return t;
   endfunction

   function automatic logic [ES_TO_MS_BUS_W-1:0] pack_es(input insn_t t);
      logic [ES_TO_MS_BUS_W-1:0] v;
      v = '0;
      v[ES_PC_LSB +: 32]    = t.pc;
      v[ES_ALU_LSB +: 32]   = t.alu;
      v[ES_DEST_LSB +: 5]   = t.dest;
      v[ES_GR_WE_BIT]       = t.gr_we;
      v[ES_LD_OP_LSB +: 5]  = t.ld_op;
      v[ES_RES_MEM_BIT]     = t.res_mem;
      v[ES_MEM_REQ_BIT]     = t.mem_req;
      v[ES_CSR_LSB +: 34]   = t.csr;
      v[ES_RKD_LSB +: 32]   = t.rkd;
      v[ES_RJ_LSB +: 32]    = t.rj;
      return v;
   endfunction

   function automatic logic [MS_TO_WS_BUS_W-1:0] exp_ws(input insn_t t, input logic [31:0] fin);
      logic [MS_TO_WS_BUS_W-1:0] v;
      v = '0;
      v[WS_PC_LSB +: 32]     = t.pc;
      v[WS_RESULT_LSB +: 32] = fin;
      v[WS_DEST_LSB +: 5]    = t.dest;
      v[WS_GR_WE_BIT]        = t.gr_we;
      v[WS_CSR_LSB +: 34]    = t.csr;
      v[WS_RKD_LSB +: 32]    = t.rkd;
      v[WS_RJ_LSB +: 32]     = t.rj;
      return v;
   endfunction

   // Shift the addressed element down, mask it, then extend by arithmetic.
   function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] a, input logic [31:0] d);
      logic [31:0] v;
      v = d;
      if (op[4] || op[1]) begin
         v = (d >> (8 * a)) & 32'h0000_00FF;
         if (op[4] && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (op[3] || op[0]) begin
         v = (d >> (16 * a[1])) & 32'h0000_FFFF;
         if (op[3] && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] fin_of(input insn_t t, input logic [31:0] rd);
      return t.res_mem ? ref_load(t.ld_op, t.alu[1:0], rd) : t.alu;
   endfunction

   function automatic logic [MS_FWD_BUS_W-1:0] fwd_exp(input insn_t t, input bit valid, input bit ready,
                                                       input logic [31:0] fin);
      logic we;
      we = valid && t.gr_we;
`ifdef MS_FWD_EN
      return {we, we && t.res_mem && !ready, t.dest, fin};
`else
      return {we, we, t.dest, 32'd0};
`endif
   endfunction

   task automatic issue(input insn_t t);
      ms_if.es_to_ms_valid = 1'b1;
      ms_if.es_to_ms_bus   = pack_es(t);
      @(negedge clk);
      checks++;
      if (ms_if.ms_allowin !== 1'b1) begin
         errors++;
         $display("FAIL issue_allowin: got %b expected 1", ms_if.ms_allowin);
      end
      @(posedge clk); #1;
      ms_if.es_to_ms_valid = 1'b0;
   endtask

   task automatic expect_empty(input string name);
      @(negedge clk);
      checks++;
      if (ms_if.ms_to_ws_valid !== 1'b0 || ms_if.ms_allowin !== 1'b1 || ms_if.ms_fwd_bus[38] !== 1'b0) begin
         errors++;
         $display("FAIL %s: valid=%b allowin=%b fwd_we=%b expected 0/1/0", name,
                  ms_if.ms_to_ws_valid, ms_if.ms_allowin, ms_if.ms_fwd_bus[38]);
      end
   endtask

   // Issue a memory instruction, deliver any owed responses first, then its own.
   task automatic run_load(input insn_t t, input int delay, input logic [31:0] rd, input int stall,
                           input logic [31:0] fin);
      logic [MS_TO_WS_BUS_W-1:0] want;
      logic [MS_FWD_BUS_W-1:0]   fw;
      want = exp_ws(t, fin);
      issue(t);
      for (int k = 0; k < model_owed + delay; k++) begin
         ms_if.data_sram_data_ok = (k < model_owed);
         ms_if.data_sram_rdata   = 32'h0000_DEAD;
         fw = fwd_exp(t, 1'b1, 1'b0, fin);
         @(negedge clk);
         checks++;
         if (ms_if.ms_to_ws_valid !== 1'b0 || ms_if.ms_allowin !== 1'b0) begin
            errors++;
            $display("FAIL ld_wait: valid=%b allowin=%b expected 0/0 (cycle %0d)",
                     ms_if.ms_to_ws_valid, ms_if.ms_allowin, k);
         end
         checks++;
         if (ms_if.ms_fwd_bus[38:32] !== fw[38:32]) begin
            errors++;
            $display("FAIL ld_wait_fwd: got %h expected %h", ms_if.ms_fwd_bus[38:32], fw[38:32]);
         end
         @(posedge clk); #1;
      end
      model_owed = 0;
      ms_if.data_sram_data_ok = 1'b1;
      ms_if.data_sram_rdata   = rd;
      ms_if.ws_allowin        = (stall == 0);
      fw = fwd_exp(t, 1'b1, 1'b1, fin);
      @(negedge clk);
      checks++;
      if (ms_if.ms_to_ws_valid !== 1'b1 || ms_if.ms_to_ws_bus !== want) begin
         errors++;
         $display("FAIL ld_data: valid=%b result=%h expected 1 result=%h", ms_if.ms_to_ws_valid,
                  ms_if.ms_to_ws_bus[WS_RESULT_LSB +: 32], fin);
      end
      checks++;
      if (ms_if.ms_fwd_bus !== fw || ms_if.ms_allowin !== (stall == 0)) begin
         errors++;
         $display("FAIL ld_data_fwd: fwd=%h allowin=%b expected fwd=%h allowin=%b",
                  ms_if.ms_fwd_bus, ms_if.ms_allowin, fw, (stall == 0));
      end
      @(posedge clk); #1;
      ms_if.data_sram_data_ok = 1'b0;
      ms_if.data_sram_rdata   = $urandom;
      for (int s = 0; s < stall; s++) begin
         ms_if.ws_allowin = (s == stall - 1);
         @(negedge clk);
         checks++;
         if (ms_if.ms_to_ws_valid !== 1'b1 || ms_if.ms_to_ws_bus !== want ||
             ms_if.ms_allowin !== (s == stall - 1)) begin
            errors++;
            $display("FAIL ld_hold: valid=%b allowin=%b result=%h expected result=%h",
                     ms_if.ms_to_ws_valid, ms_if.ms_allowin, ms_if.ms_to_ws_bus[WS_RESULT_LSB +: 32], fin);
         end
         @(posedge clk); #1;
      end
      ms_if.ws_allowin = 1'b1;
      expect_empty("ld_left");
      @(posedge clk); #1;
   endtask

   // Park a load with no response, then flush it: one response becomes owed.
   task automatic flush_pending();
      insn_t t;
      t = rand_insn(1'b1);
      issue(t);
      @(negedge clk);
      checks++;
      if (ms_if.ms_to_ws_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_wait: valid=%b expected 0", ms_if.ms_to_ws_valid);
      end
      @(posedge clk); #1;
      ms_if.wb_ex = 1'b1;
      @(posedge clk); #1;
      ms_if.wb_ex = 1'b0;
      model_owed++;
      expect_empty("flush_empty");
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      expect_empty("reset_state");
      checks++;
      if (ms_if.ms_fwd_bus[37] !== 1'b0) begin
         errors++;
         $display("FAIL reset_fwd_block: got %b expected 0", ms_if.ms_fwd_bus[37]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_alu();
      insn_t t;
      for (int i = 0; i < 16; i++) begin
         t = rand_insn(1'b0);
         if (i == 0) t.alu = 32'h0000_1234;
         issue(t);
         @(negedge clk);
         checks++;
         if (ms_if.ms_to_ws_valid !== 1'b1 || ms_if.ms_to_ws_bus !== exp_ws(t, t.alu)) begin
            errors++;
            $display("FAIL alu_out: valid=%b bus=%h expected bus=%h", ms_if.ms_to_ws_valid,
                     ms_if.ms_to_ws_bus, exp_ws(t, t.alu));
         end
         checks++;
         if (ms_if.ms_fwd_bus !== fwd_exp(t, 1'b1, 1'b1, t.alu)) begin
            errors++;
            $display("FAIL alu_fwd: got %h expected %h", ms_if.ms_fwd_bus, fwd_exp(t, 1'b1, 1'b1, t.alu));
         end
         @(posedge clk); #1;
      end
      expect_empty("alu_drained");
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      insn_t q[$];
      insn_t h;
      bit    hv = 1'b0;
      bit    exp_allow;
      int    idx = 0;
      int    cyc = 0;
      for (int i = 0; i < 20; i++) q.push_back(rand_insn(1'b0));
      while ((idx < 20 || hv) && cyc < 200) begin
         ms_if.es_to_ms_valid = (idx < 20);
         if (idx < 20) ms_if.es_to_ms_bus = pack_es(q[idx]);
         ms_if.ws_allowin = ($urandom_range(0, 3) != 0);
         exp_allow = !hv || ms_if.ws_allowin;
         @(negedge clk);
         checks++;
         if (ms_if.ms_to_ws_valid !== hv || ms_if.ms_allowin !== exp_allow) begin
            errors++;
            $display("FAIL b2b_handshake: valid=%b allowin=%b expected %b/%b", ms_if.ms_to_ws_valid,
                     ms_if.ms_allowin, hv, exp_allow);
         end
         if (hv) begin
            checks++;
            if (ms_if.ms_to_ws_bus !== exp_ws(h, h.alu)) begin
               errors++;
               $display("FAIL b2b_bus: got %h expected %h", ms_if.ms_to_ws_bus, exp_ws(h, h.alu));
            end
         end
         @(posedge clk); #1;
         if (exp_allow) begin
            hv = (idx < 20);
            if (idx < 20) begin
               h = q[idx];
               idx++;
            end
         end
         cyc++;
      end
      checks++;
      if (cyc >= 200) begin
         errors++;
         $display("FAIL b2b_timeout: %0d of 20 accepted", idx);
      end
      ms_if.es_to_ms_valid = 1'b0;
      ms_if.ws_allowin     = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_load();
      insn_t t;
      logic [31:0] rd;
      t = rand_insn(1'b1);
      t.res_mem = 1'b1;
      t.gr_we   = 1'b1;
      t.dest    = 5'd7;
      t.ld_op   = 5'b10000;
      t.alu     = {t.alu[31:2], 2'b01};
      run_load(t, 2, 32'h0000_8000, 0, 32'hFFFF_FF80);
      t.ld_op   = 5'b00010;
      run_load(t, 2, 32'h0000_8000, 0, 32'h0000_0080);
      t.ld_op   = 5'b01000;
      t.alu     = {t.alu[31:2], 2'b10};
      run_load(t, 1, 32'h8001_0000, 4, 32'hFFFF_8001);
      t.ld_op   = 5'b00001;
      run_load(t, 0, 32'h8001_0000, 1, 32'h0000_8001);
      t.ld_op   = 5'b00100;
      run_load(t, 3, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
      for (int i = 0; i < 24; i++) begin
         t  = rand_insn(1'b1);
         rd = $urandom;
         run_load(t, $urandom_range(0, 3), rd, $urandom_range(0, 2), fin_of(t, rd));
      end
   endtask

   task automatic test_flush();
      insn_t t;
      logic [31:0] rd;
      // one owed response: 0xDEAD is dropped, the next response is the load's
      flush_pending();
      t = rand_insn(1'b1);
      t.res_mem = 1'b1;
      t.ld_op   = 5'b00100;
      t.alu     = {t.alu[31:2], 2'b00};
      run_load(t, 0, 32'h0000_0005, 0, 32'h0000_0005);
      // two owed responses
      flush_pending();
      flush_pending();
      t  = rand_insn(1'b1);
      rd = $urandom;
      run_load(t, 1, rd, 1, fin_of(t, rd));
      // flush in the same cycle execute presents: nothing accepted, nothing owed
      ms_if.es_to_ms_valid = 1'b1;
      ms_if.es_to_ms_bus   = pack_es(rand_insn(1'b0));
      ms_if.wb_ex          = 1'b1;
      @(posedge clk); #1;
      ms_if.es_to_ms_valid = 1'b0;
      ms_if.wb_ex          = 1'b0;
      expect_empty("flush_same_cycle");
      @(posedge clk); #1;
      // flush of a load that already captured its data while stalled
      t = rand_insn(1'b1);
      issue(t);
      ms_if.data_sram_data_ok = 1'b1;
      ms_if.data_sram_rdata   = $urandom;
      ms_if.ws_allowin        = 1'b0;
      @(posedge clk); #1;
      ms_if.data_sram_data_ok = 1'b0;
      ms_if.wb_ex             = 1'b1;
      @(posedge clk); #1;
      ms_if.wb_ex      = 1'b0;
      ms_if.ws_allowin = 1'b1;
      expect_empty("flush_captured");
      @(posedge clk); #1;
      // flush coinciding with the load's own response
      t = rand_insn(1'b1);
      issue(t);
      ms_if.data_sram_data_ok = 1'b1;
      ms_if.data_sram_rdata   = $urandom;
      ms_if.wb_ex             = 1'b1;
      @(posedge clk); #1;
      ms_if.data_sram_data_ok = 1'b0;
      ms_if.wb_ex             = 1'b0;
      expect_empty("flush_with_data");
      @(posedge clk); #1;
      // flush of a stalled ALU instruction
      ms_if.ws_allowin = 1'b0;
      issue(rand_insn(1'b0));
      ms_if.wb_ex = 1'b1;
      @(posedge clk); #1;
      ms_if.wb_ex      = 1'b0;
      ms_if.ws_allowin = 1'b1;
      expect_empty("flush_alu");
      @(posedge clk); #1;
      // none of the last four flushes owed anything: first response is used
      t  = rand_insn(1'b1);
      rd = $urandom;
      run_load(t, 0, rd, 0, fin_of(t, rd));
   endtask

   task automatic test_reset_mid();
      insn_t t;
      logic [31:0] rd;
      flush_pending();
      t = rand_insn(1'b1);
      issue(t);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_owed = 0;
      expect_empty("reset_mid");
      @(posedge clk); #1;
      t  = rand_insn(1'b1);
      rd = $urandom;
      run_load(t, 0, rd, 0, fin_of(t, rd));
   endtask

   initial begin
      reset                   = 1'b1;
      ms_if.ws_allowin        = 1'b1;
      ms_if.es_to_ms_valid    = 1'b0;
      ms_if.es_to_ms_bus      = '0;
      ms_if.data_sram_data_ok = 1'b0;
      ms_if.data_sram_rdata   = '0;
      ms_if.wb_ex             = 1'b0;
      test_reset();
      test_alu();
      test_back_to_back();
      test_load();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order core: it sits between the execute stage and the write-back stage. It holds one instruction and, for instructions whose data-SRAM request was accepted in execute, waits for the data response. It aligns and extends load data and forwards the result onto the fixed 168-bit bus that write-back consumes. It also publishes a forwarding/blocking bus to decode, and discards in-flight data responses on an exception flush.

## Interface
Parameters: none; bus widths are fixed constants in the shared package.

- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ws_allowin  in  1  write-back can accept this cycle
- ms_allowin  out  1  this stage can accept from execute
- es_to_ms_valid  in  1  execute presents a valid instruction
- es_to_ms_bus  in  175  {rj_value[32], rkd_value[32], csr_data[34], mem_req, res_from_mem, ld_op[5] one-hot {b,h,w,bu,hu}, gr_we, dest[5], alu_result[32], pc[32]}
- ms_to_ws_valid  out  1  valid instruction offered to write-back
- ms_to_ws_bus  out  168  {rj_value, rkd_value, csr_data, gr_we, dest[5], final_result[32], pc[32]}
- data_sram_data_ok  in  1  data response strobe, one per accepted request, in order
- data_sram_rdata  in  32  response data, valid with data_ok
- wb_ex  in  1  exception flush from write-back
- ms_fwd_bus  out  39  {fwd_we, fwd_block, fwd_dest[5], fwd_data[32]} to decode

## Operation
- State registers:
  - ms_valid
  - es_to_ms_bus_r, the 175-bit latched bus
  - got_data and data_buf[32], captured response
  - drop_cnt[1:0], responses still owed to flushed instructions
- Latch: when es_to_ms_valid && ms_allowin, load es_to_ms_bus_r. If the latch occurs, clear got_data.
- ms_valid update, in priority order:
  - reset → 0
  - wb_ex → 0
  - ms_allowin → es_to_ms_valid
- Response capture: a data_ok arriving with drop_cnt == 0 belongs to the current instruction. Set got_data and store data_buf.
- Dropping: a data_ok arriving with drop_cnt != 0 is discarded and decrements drop_cnt.
- Flush accounting: on wb_ex with ms_valid && mem_req && !got_data and no same-cycle captured data_ok, increment drop_cnt.
- wb_ex also clears got_data.
- ms_ready_go = !mem_req || got_data || (data_ok && drop_cnt == 0).
- The load data source is data_ok-cycle rdata when data arrives this cycle, otherwise data_buf.
- Load alignment uses addr = alu_result[1:0]:
  - b selects byte addr, sign-extended.
  - bu selects byte addr, zero-extended.
  - h selects halfword addr[1], sign-extended.
  - hu selects halfword addr[1], zero-extended.
  - w passes all 32 bits.
- final_result = res_from_mem ? aligned load : alu_result. All other fields pass through unchanged.
- Forwarding outputs:
  - fwd_we = ms_valid && gr_we
  - fwd_block = fwd_we && res_from_mem && !ms_ready_go
  - fwd_dest = dest
  - fwd_data = final_result

## Timing
- Reset values:
  - ms_valid, got_data and drop_cnt are 0.
  - ms_allowin = 1.
  - ms_to_ws_valid = 0.
  - fwd_we and fwd_block are 0.
- Handshake signals:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Latency:
  - A non-memory instruction stays 1 cycle.
  - A load whose data_ok arrives in cycle N leaves at the end of N if ws_allowin is high. Otherwise it waits with data held in data_buf.
- Write-back backpressure never loses a captured response.
- Simultaneous events:
  - wb_ex and es_to_ms_valid in the same cycle: the incoming instruction is not accepted, ms_valid = 0. The bus register may load but the data is dead.
- drop_cnt saturates at 3. The core never has more than 2 outstanding flushed requests; exceeding this is a checker error.
- Reset mid-wait clears every counter. Memory side responses after reset are not expected.

## Configuration
- MS_FWD_EN defined: ms_fwd_bus behaves as specified.
- MS_FWD_EN undefined:
  - fwd_data is tied to 0.
  - fwd_block = fwd_we, so decode stalls on any destination match.
  - fwd_we and fwd_dest are unchanged.

## Structure
- Shared package holds:
  - bus widths ES_TO_MS_BUS_W = 175, MS_TO_WS_BUS_W = 168, MS_FWD_BUS_W = 39
  - ld_op bit indices
  - field offset constants used by the execute and write-back stages
- One sub-module: load_align (ld_op, addr[1:0], rdata → aligned 32-bit value), purely combinational.

## Test plan
1. ALU op, alu_result = 0x1234, ws_allowin = 1 → ms_to_ws_valid the cycle after latch, final_result = 0x1234.
2. ld_b at addr ...01, data_ok 2 cycles later with rdata = 0x0000_8000 → final_result = 0xFFFF_FF80. With ld_bu → 0x0000_0080.
3. ld_h at addr[1] = 1 with rdata 0x8001_0000 → 0xFFFF_8001. With ws_allowin = 0 for 3 cycles after data_ok → data held, ms_allowin = 0, released unchanged.
4. Load pending with no data_ok, then wb_ex → drop_cnt = 1. Next instruction is a load whose first data_ok (0xDEAD) is dropped and second (0x0000_0005) is used → final_result = 5.
5. Pending load with gr_we and dest = 7 → fwd_block = 1 until data_ok, then fwd_data equals the aligned value. With MS_FWD_EN undefined → fwd_block = 1 for any valid gr_we instruction.
6. Assert reset while a load is waiting → next cycle ms_valid = 0, drop_cnt = 0, ms_allowin = 1.
